// File: rtl/microop_sequencer.sv
// microop_sequencer
//   Sequences the microcode store. After reset it optionally runs a bootstrap
//   loader that streams bytes into the store. It then steps the micro-op
//   counter and loads the opcode register as the current microcode word
//   directs. The microcode address is {opcode_q, count_q}.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   BOOT_IDLE  | loader ready, waiting for a bootstrap byte
//   BOOT_WRITE | one-cycle active-low write strobe for the latched byte
//   RUN        | executing microcode, one word per unstalled cycle
//   FAULT      | micro-op count overran 31; frozen until reset
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   ctrl_in_i             current microcode word ([24] opcode_sel,
//                         [15] misc/count reset, [14:12] in_plane)
//   bus_opcode_i          opcode source when opcode_sel=1
//   opword_opcode_i       opcode source when opcode_sel=0
//   stall_i               hold the sequencer this cycle
//   uaddr_o               microcode address {opcode_q, count_q}
//   step_en_o             current word executes this cycle
//   uop_fault_o           sticky count-overrun flag
//   boot_valid_i/data_i   bootstrap byte offer
//   boot_ready_o          loader accepts a byte this cycle
//   bootstrap_addr_o      byte address into the microcode store
//   bootstrap_data_o      byte to write
//   bootstrap_n_we_o      active-low write strobe
//   n_booted_o            high until bootstrap completes
module microop_sequencer #(
  parameter bit BOOTSTRAP  = 1'b1,
  parameter int BOOT_BYTES = 8192
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ctrl_in_i,
  input  logic [5:0]  bus_opcode_i,
  input  logic [5:0]  opword_opcode_i,
  input  logic        stall_i,
  output logic [10:0] uaddr_o,
  output logic        step_en_o,
  output logic        uop_fault_o,
  input  logic        boot_valid_i,
  input  logic [7:0]  boot_data_i,
  output logic        boot_ready_o,
  output logic [12:0] bootstrap_addr_o,
  output logic [7:0]  bootstrap_data_o,
  output logic        bootstrap_n_we_o,
  output logic        n_booted_o
);

  typedef enum logic [1:0] {
    BOOT_IDLE  = 2'd0,
    BOOT_WRITE = 2'd1,
    RUN        = 2'd2,
    FAULT      = 2'd3
  } state_e;

  localparam state_e      ENTRY_STATE = BOOTSTRAP ? BOOT_IDLE : RUN;
  localparam logic [12:0] LAST_BYTE   = 13'(BOOT_BYTES - 1);
  localparam logic [2:0]  IN_OPCODE   = 3'd6;

  state_e      state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [4:0]  count_q, count_d;
  logic [12:0] byte_cnt_q, byte_cnt_d;
  logic [12:0] boot_addr_q, boot_addr_d;
  logic [7:0]  boot_data_q, boot_data_d;
  logic        fault_q, fault_d;

  logic       misc;
  logic [2:0] in_plane;
  logic       opcode_sel;
  logic       unused_ctrl;

  assign misc        = ctrl_in_i[15];
  assign in_plane    = ctrl_in_i[14:12];
  assign opcode_sel  = ctrl_in_i[24];
  assign unused_ctrl = ^{ctrl_in_i[31:25], ctrl_in_i[23:16], ctrl_in_i[11:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ENTRY_STATE;
      opcode_q    <= 6'd0;
      count_q     <= 5'd0;
      byte_cnt_q  <= 13'd0;
      boot_addr_q <= 13'd0;
      boot_data_q <= 8'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      count_q     <= count_d;
      byte_cnt_q  <= byte_cnt_d;
      boot_addr_q <= boot_addr_d;
      boot_data_q <= boot_data_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    opcode_d         = opcode_q;
    count_d          = count_q;
    byte_cnt_d       = byte_cnt_q;
    boot_addr_d      = boot_addr_q;
    boot_data_d      = boot_data_q;
    fault_d          = fault_q;
    step_en_o        = 1'b0;
    boot_ready_o     = 1'b0;
    bootstrap_n_we_o = 1'b1;

    case (state_q)
      BOOT_IDLE: begin
        boot_ready_o = 1'b1;
        if (boot_valid_i) begin
          boot_data_d = boot_data_i;
          boot_addr_d = byte_cnt_q;
          state_d     = BOOT_WRITE;
        end
      end
      BOOT_WRITE: begin
        bootstrap_n_we_o = 1'b0;
        if (byte_cnt_q == LAST_BYTE) begin
          state_d = RUN;
        end else begin
          byte_cnt_d = byte_cnt_q + 13'd1;
          state_d    = BOOT_IDLE;
        end
      end
      RUN: begin
        step_en_o = !stall_i;
        if (!stall_i) begin
          if (in_plane == IN_OPCODE) begin
            opcode_d = opcode_sel ? bus_opcode_i : opword_opcode_i;
          end
          // Counter reset takes priority over overrun detection.
          if (misc) begin
            count_d = 5'd0;
          end else if (count_q == 5'd31) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            count_d = count_q + 5'd1;
          end
        end
      end
      FAULT: begin
      end
      default: state_d = ENTRY_STATE;
    endcase
  end

  assign uaddr_o          = {opcode_q, count_q};
  assign uop_fault_o      = fault_q;
  assign bootstrap_addr_o = boot_addr_q;
  assign bootstrap_data_o = boot_data_q;
  // The microcode output enable must stay off until the store is loaded.
  assign n_booted_o       = (state_q == BOOT_IDLE) || (state_q == BOOT_WRITE);

endmodule
